ram1p_arbiter: RTL
==================

// Module: ram1p_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM (1 access/cycle, registered read address, 1-cycle read latency)
//  between a read requester (cache lookup) and a write requester (line fill / tag update).
//  Fixed write-over-read priority with an anti-starvation counter; optional post-reset clear sweep.
//  Sits between cache FSM/datapath and the ram1p1rwe-class array; drives its ce/we/addr/din.
// PARAMETERS
//  DEPTH       64  number of RAM words
//  WIDTH       44  bits per word
//  STARVE_MAX  4   consecutive lost read contentions before read is forced to win (>=1)
// PORTS
//  clk       in   1               clock
//  reset     in   1               synchronous, active-high reset
//  RdReq     in   1               read request; held stable with RdAddr until RdGnt
//  RdAddr    in   $clog2(DEPTH)   read address
//  RdGnt     out  1               read granted this cycle (combinational)
//  RdValid   out  1               RdData valid (cycle after RdGnt)
//  RdData    out  WIDTH           read data (= RamDout)
//  WrReq     in   1               write request; held stable with WrAddr/WrData until WrGnt
//  WrAddr    in   $clog2(DEPTH)   write address
//  WrData    in   WIDTH           write data
//  WrGnt     out  1               write granted this cycle (combinational)
//  ClearReq  in   1               start clear sweep (macro only)
//  Busy      out  1               clear sweep in progress; no grants
//  RamCE     out  1               RAM chip enable
//  RamWe     out  1               RAM write enable
//  RamAddr   out  $clog2(DEPTH)   RAM address
//  RamDin    out  WIDTH           RAM write data
//  RamDout   in   WIDTH           RAM read data
// BEHAVIOUR
//  - Reset: RdValid=0, StarveCnt=0, Busy=0 (=1 with macro), no grants.
//  - At most one grant per cycle. Grants are combinational from requests and registered state.
//  - Arbitration when not Busy:
//      WrReq & !RdReq -> WrGnt.  RdReq & !WrReq -> RdGnt.
//      both: WrGnt, unless StarveCnt==STARVE_MAX, then RdGnt.
//  - StarveCnt ($clog2(STARVE_MAX+1) bits):
//      +1 when RdReq & !RdGnt & !Busy; saturates at STARVE_MAX.
//      Cleared when RdGnt=1 or RdReq=0.
//  - RAM drive:
//      RamCE = RdGnt|WrGnt|Busy
//      RamWe = WrGnt|Busy
//      RamAddr = granted addr (clear counter when Busy)
//      RamDin = WrData (0 when Busy)
//  - Read latency 1: RdValid = registered RdGnt (one-cycle pulse per grant).
//      RdData holds last read word until the next RamCE; holding it is not guaranteed after any write.
//  - Same-cycle read+write to same address: write wins (absent starvation).
//      No forwarding; the re-requested read returns the new data.
//  - Requester may drop its request only after its grant; behaviour when dropped ungranted is undefined.
// CONFIGURATION
//  RAM1P_ARB_INITCLR_EN defined:
//    - FSM CLEAR/READY; reset enters CLEAR with ClrAddr=0.
//    - CLEAR: Busy=1, RamWe=1, RamDin=0, RamAddr=ClrAddr; ClrAddr+1 per cycle.
//    - Exits to READY the cycle after ClrAddr==DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
//    - READY & ClearReq -> CLEAR (ClrAddr=0). ClearReq ignored in CLEAR.
//    - Reset mid-sweep restarts at 0. Pending requests wait, ungranted.
//  RAM1P_ARB_INITCLR_EN undefined:
//    - Busy tied 0, ClearReq ignored, no FSM; RAM contents after reset are undefined.
// TESTING
//  1 [macro] Release reset -> Busy=1 for 64 cycles, RamWe=1, RamAddr 0..63, RamDin=0.
//    Then read addr 5 -> RdData=0.
//  2 WrReq addr 3 data 0xABC, next cycle RdReq addr 3 -> WrGnt, then RdGnt.
//    RdValid=1 one cycle later with RdData=0xABC.
//  3 RdReq and WrReq held high continuously, STARVE_MAX=4 -> WrGnt cycles 1-4, RdGnt cycle 5.
//    StarveCnt=0 afterward; pattern repeats.
//  4 Addr 7 holds 0x1; same-cycle Rd/Wr addr 7 (Wr data 0x2) -> WrGnt.
//    RdGnt next cycle; RdData=0x2.
//  5 [macro] Reset asserted at ClrAddr=20 -> sweep restarts at 0.
//    Busy for a full 64 cycles after release; RdReq held throughout is granted the first READY cycle.
//  6 Read addr 9 (0x55), then idle 3 cycles -> RdValid high 1 cycle only.
//    RdData=0x55 stable all 3 idle cycles; RamCE=0.

Source files
------------

// File: rtl/ram1p_arbiter.sv
// ram1p_arbiter: shares one single-port SRAM between a read and a write requester,
// write-over-read with read anti-starvation; RAM1P_ARB_INITCLR_EN adds a zero-clear sweep.
module ram1p_arbiter #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 44,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RdReq,
    input  logic [$clog2(DEPTH)-1:0] RdAddr,
    output logic                     RdGnt,
    output logic                     RdValid,
    output logic [WIDTH-1:0]         RdData,
    input  logic                     WrReq,
    input  logic [$clog2(DEPTH)-1:0] WrAddr,
    input  logic [WIDTH-1:0]         WrData,
    output logic                     WrGnt,
    input  logic                     ClearReq,
    output logic                     Busy,
    output logic                     RamCE,
    output logic                     RamWe,
    output logic [$clog2(DEPTH)-1:0] RamAddr,
    output logic [WIDTH-1:0]         RamDin,
    input  logic [WIDTH-1:0]         RamDout
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          busy;
    logic [AW-1:0] clr_addr;
    logic [SW-1:0] starve_reg;
    logic          rd_valid_reg;
    logic          starved;
    logic          rd_gnt;
    logic          wr_gnt;

`ifdef RAM1P_ARB_INITCLR_EN
    typedef enum logic {S_CLEAR, S_READY} state_t;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_reg;
    logic          busy_reg;
    logic [AW-1:0] clr_addr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_CLEAR;
            busy_reg     <= 1'b1;
            clr_addr_reg <= '0;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + AW'(1);
                    if (clr_addr_reg == LAST_ADDR) begin
                        state_reg    <= S_READY;
                        busy_reg     <= 1'b0;
                        clr_addr_reg <= '0;
                    end
                end
                default: begin
                    if (ClearReq) begin
                        state_reg    <= S_CLEAR;
                        busy_reg     <= 1'b1;
                        clr_addr_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign clr_addr = clr_addr_reg;
`else
    logic clear_req_unused;
    assign clear_req_unused = ClearReq;
    assign busy             = 1'b0;
    assign clr_addr         = '0;
`endif

    // Read wins a contention only once it has lost STARVE_MAX in a row.
    assign starved = (starve_reg == STARVE_LIM);
    assign rd_gnt  = !reset && !busy && RdReq && (!WrReq || starved);
    assign wr_gnt  = !reset && !busy && WrReq && !(RdReq && starved);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_gnt;
            if (!RdReq || rd_gnt)
                starve_reg <= '0;
            else if (!busy && !starved)
                starve_reg <= starve_reg + SW'(1);
        end
    end

    assign RdGnt   = rd_gnt;
    assign WrGnt   = wr_gnt;
    assign RdValid = rd_valid_reg;
    assign RdData  = RamDout;
    assign Busy    = busy;

    assign RamCE   = rd_gnt | wr_gnt | busy;
    assign RamWe   = wr_gnt | busy;
    assign RamAddr = busy ? clr_addr : (wr_gnt ? WrAddr : RdAddr);
    assign RamDin  = busy ? '0 : WrData;
endmodule
